rtc_wb_arbiter: RTL and testbench

- Two-master Wishbone arbiter and sequencer in front of the rtcclock register slave (3-bit address, 32-bit data).
- Shares the slave between the management SoC (m0) and the logic-analyzer host path (m1).
- Applies round-robin priority and bus locking while a master holds cyc.
- The slave has no ack and returns registered read data one cycle after the address. This block generates the strobe, ack and read-data capture timing for it.

---
 rtl/rtc_wb_arbiter_if.sv | 69 ++++++
 rtl/rtc_wb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_rtc_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rtc_wb_arbiter_if
//   Bundles the two Wishbone master ports and the rtcclock slave port seen by
//   rtc_wb_arbiter. Signal names keep the arbiter's own _i/_o direction suffixes.
//
//   Modports:
//     slave  : the arbiter's view. It receives m0/m1 requests and s_dat_i, and
//              drives the m0/m1 responses, the s_* slave bus and grant_o.
//     master : the environment's view. It drives both masters and the slave
//              read data, and observes everything the arbiter drives.
//
//   Signals (per master N in {0,1}):
//     mN_cyc_i, mN_stb_i, mN_we_i, mN_adr_i[ADDR_W], mN_dat_i[DATA_W]
//     mN_ack_o, mN_err_o, mN_dat_o[DATA_W]
//   Slave side:
//     s_cyc_o, s_stb_o, s_we_o, s_adr_o[ADDR_W], s_dat_o[DATA_W], s_dat_i[DATA_W]
//   grant_o[2] : one-hot owner, 00 when idle
// -----------------------------------------------------------------------------
interface rtc_wb_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic              m0_ack_o;
    logic              m0_err_o;
    logic [DATA_W-1:0] m0_dat_o;

    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [DATA_W-1:0] m1_dat_i;
    logic              m1_ack_o;
    logic              m1_err_o;
    logic [DATA_W-1:0] m1_dat_o;

    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [DATA_W-1:0] s_dat_o;
    logic [DATA_W-1:0] s_dat_i;

    logic [1:0]        grant_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        input  s_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        output s_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  grant_o
    );
endinterface

// File: rtl/rtc_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_wb_arbiter
//   Two-master Wishbone arbiter/sequencer in front of the rtcclock register
//   slave. The slave has no ack and returns registered read data one cycle
//   after the address, so this block creates the strobe, ack and capture
//   timing: request (IDLE) -> s_stb_o (ISSUE) -> ack + data (CAPT).
//   Round-robin between m0 and m1; the owner keeps the bus while it holds cyc,
//   but an idle owner is forced off after HOLD_MAX cycles if the other waits.
//
//   Ports:
//     wb_clk_i : clock
//     wb_rst_i : asynchronous active-high reset
//     bus      : rtc_wb_arbiter_if.slave (m0/m1 master ports, s_* slave port,
//                grant_o)
//
//   Optional feature macro RTC_ARB_WPROT_EN: when defined, writes to addresses
//   5..7 (read-only hack registers) are refused with a one-cycle mN_err_o and
//   never reach the slave. When undefined, mN_err_o is tied low.
// -----------------------------------------------------------------------------
module rtc_wb_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 15
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    rtc_wb_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, HELD, ERR} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
`ifdef RTC_ARB_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;
    logic [7:0]        hold_q, hold_d;
    logic              s_we_q, s_we_d;
    logic [ADDR_W-1:0] s_adr_q, s_adr_d;
    logic [DATA_W-1:0] s_dat_q, s_dat_d;
    logic [DATA_W-1:0] m0_dat_q, m0_dat_d;
    logic [DATA_W-1:0] m1_dat_q, m1_dat_d;

    logic              m0_req, m1_req, pick, src, start;
    logic              own_cyc, own_req, oth_req, capt;
    logic              src_we;
    logic [ADDR_W-1:0] src_adr;
    logic [DATA_W-1:0] src_dat;

    function automatic logic wprot(input logic we, input logic [ADDR_W-1:0] adr);
        return WPROT_EN && we && (adr >= ADDR_W'(5));
    endfunction

    assign m0_req = bus.m0_cyc_i & bus.m0_stb_i;
    assign m1_req = bus.m1_cyc_i & bus.m1_stb_i;

    // Only a contested request looks at last; last starts at 1 so m0 wins first.
    assign pick = (m0_req & m1_req) ? ~last_q : m1_req;

    // A new transfer is taken from the arbitration winner when idle, otherwise
    // from the current owner.
    assign src     = (state_q == IDLE) ? pick : grant_q[1];
    assign src_we  = src ? bus.m1_we_i  : bus.m0_we_i;
    assign src_adr = src ? bus.m1_adr_i : bus.m0_adr_i;
    assign src_dat = src ? bus.m1_dat_i : bus.m0_dat_i;

    assign own_cyc = grant_q[1] ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign own_req = grant_q[1] ? m1_req : m0_req;
    assign oth_req = grant_q[1] ? m0_req : m1_req;
    assign capt    = (state_q == CAPT);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        hold_d   = hold_q;
        s_we_d   = s_we_q;
        s_adr_d  = s_adr_q;
        s_dat_d  = s_dat_q;
        m0_dat_d = m0_dat_q;
        m1_dat_d = m1_dat_q;
        start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    start   = 1'b1;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                if (grant_q[1]) m1_dat_d = bus.s_dat_i;
                else            m0_dat_d = bus.s_dat_i;
                last_d = grant_q[1];
                hold_d = '0;
                // An owner that dropped cyc mid-transfer is released right away.
                if (own_cyc) begin
                    state_d = HELD;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            HELD: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end else if (own_req) begin
                    start = 1'b1;
                end else if (oth_req) begin
                    if (hold_q + 8'd1 >= HOLD_LIM) begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            ERR: begin
                last_d = grant_q[1];
                hold_d = '0;
                if (own_cyc) begin
                    state_d = HELD;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Refused writes never touch the s_* registers, so the slave sees nothing.
        if (start) begin
            hold_d = '0;
            if (wprot(src_we, src_adr)) begin
                state_d = ERR;
            end else begin
                state_d = ISSUE;
                s_we_d  = src_we;
                s_adr_d = src_adr;
                s_dat_d = src_dat;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= 1'b1;
            hold_q   <= '0;
            s_we_q   <= 1'b0;
            s_adr_q  <= '0;
            s_dat_q  <= '0;
            m0_dat_q <= '0;
            m1_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            s_we_q   <= s_we_d;
            s_adr_q  <= s_adr_d;
            s_dat_q  <= s_dat_d;
            m0_dat_q <= m0_dat_d;
            m1_dat_q <= m1_dat_d;
        end
    end

    assign bus.s_cyc_o = (state_q == ISSUE) | (state_q == CAPT) | (state_q == HELD);
    assign bus.s_stb_o = (state_q == ISSUE);
    assign bus.s_we_o  = s_we_q;
    assign bus.s_adr_o = s_adr_q;
    assign bus.s_dat_o = s_dat_q;
    assign bus.grant_o = grant_q;

    assign bus.m0_ack_o = capt & grant_q[0];
    assign bus.m1_ack_o = capt & grant_q[1];

    // Slave data is only valid in the CAPT cycle: pass it through during the
    // ack, then present the copy captured at the end of that cycle.
    assign bus.m0_dat_o = (capt & grant_q[0]) ? bus.s_dat_i : m0_dat_q;
    assign bus.m1_dat_o = (capt & grant_q[1]) ? bus.s_dat_i : m1_dat_q;

`ifdef RTC_ARB_WPROT_EN
    assign bus.m0_err_o = (state_q == ERR) & grant_q[0];
    assign bus.m1_err_o = (state_q == ERR) & grant_q[1];
`else
    assign bus.m0_err_o = 1'b0;
    assign bus.m1_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_wb_arbiter
//   Directed bench for rtc_wb_arbiter. Stimulus pushes the expected response
//   (ack or err, read data, cycle number) into a per-master queue; a monitor
//   on the falling edge pops and compares whenever the DUT acks or errs.
//   A small register-file model stands in for the rtcclock slave.
// -----------------------------------------------------------------------------
module tb_rtc_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;
    int   c0;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    rtc_wb_arbiter_if #(.ADDR_W(3), .DATA_W(32)) bus ();

    rtc_wb_arbiter #(.ADDR_W(3), .DATA_W(32), .HOLD_MAX(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // rtcclock slave model: registered address mux, write on cyc & stb & we.
    logic [31:0] regs [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 32'hA0A0_0000 + 32'(i);
            regs[2] <= 32'h0012_3456;
        end else if (bus.s_cyc_o && bus.s_stb_o && bus.s_we_o) begin
            regs[bus.s_adr_o] <= bus.s_dat_o;
        end
        bus.s_dat_i <= regs[bus.s_adr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic mon(input int m, input logic ack, input logic err, input logic [31:0] dat);
        exp_t e;
        int   sz;
        if (ack || err) begin
            n_tests++;
            sz = (m == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                n_fail++;
                $display("FAIL m%0d_resp: got unexpected ack=%0b err=%0b at cycle %0d, required none",
                         m, ack, err, cyc_cnt);
            end else begin
                if (m == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (err !== e.err || ack !== !e.err || cyc_cnt != e.cyc ||
                    (!e.err && dat !== e.dat)) begin
                    n_fail++;
                    $display("FAIL m%0d_resp: got ack=%0b err=%0b dat=%08h cycle=%0d, required err=%0b dat=%08h cycle=%0d",
                             m, ack, err, dat, cyc_cnt, e.err, e.dat, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o);
        mon(1, bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o);
    end

    task automatic expect_resp(input int m, input logic err, input logic [31:0] dat, input int cyc);
        exp_t e;
        e.err = err;
        e.dat = dat;
        e.cyc = cyc;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int m, input logic we, input logic [2:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = we;
            bus.m0_adr_i = adr;  bus.m0_dat_i = dat;
        end else begin
            bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = we;
            bus.m1_adr_i = adr;  bus.m1_dat_i = dat;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) begin
            bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
        end else begin
            bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        end
    endtask

    // Single read from IDLE: ack two cycles later, release, back in IDLE.
    task automatic xfer_rd(input int m, input logic [2:0] adr, input logic [31:0] dat);
        int c;
        c = cyc_cnt;
        go(m, 1'b0, adr, 32'h0);
        expect_resp(m, 1'b0, dat, c + 2);
        tick(); tick(); tick();
        drop(m);
        tick();
    endtask

    initial begin
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
        bus.m0_adr_i = '0;   bus.m0_dat_i = '0;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        bus.m1_adr_i = '0;   bus.m1_dat_i = '0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_grant",  32'(bus.grant_o),  32'd0);
        chk("rst_s_cyc",  32'(bus.s_cyc_o),  32'd0);
        chk("rst_s_stb",  32'(bus.s_stb_o),  32'd0);
        chk("rst_s_we",   32'(bus.s_we_o),   32'd0);
        chk("rst_s_adr",  32'(bus.s_adr_o),  32'd0);
        chk("rst_s_dat",  bus.s_dat_o,       32'd0);
        chk("rst_m0_dat", bus.m0_dat_o,      32'd0);
        chk("rst_m1_dat", bus.m1_dat_o,      32'd0);
        chk("rst_acks",   32'({bus.m0_ack_o, bus.m1_ack_o}), 32'd0);
        chk("rst_errs",   32'({bus.m0_err_o, bus.m1_err_o}), 32'd0);
        tick();
        rst = 1'b0;

        // Simultaneous requests from reset: m0, then m1, then m0 again
        c0 = cyc_cnt;
        go(0, 1'b0, 3'd1, 32'h0);
        go(1, 1'b0, 3'd3, 32'h0);
        expect_resp(0, 1'b0, 32'hA0A0_0001, c0 + 2);
        expect_resp(1, 1'b0, 32'hA0A0_0003, c0 + 6);
        tick(); tick(); tick();                       // c0+3
        drop(0);
        tick(); tick();                               // c0+5
        @(negedge clk); chk("rr_grant_m1", 32'(bus.grant_o), 32'd2);
        tick(); tick();                               // c0+7
        drop(1);
        tick();                                       // c0+8
        go(0, 1'b0, 3'd4, 32'h0);
        go(1, 1'b0, 3'd0, 32'h0);
        expect_resp(0, 1'b0, 32'hA0A0_0004, c0 + 10);
        expect_resp(1, 1'b0, 32'hA0A0_0000, c0 + 14);
        tick(); tick(); tick();                       // c0+11
        drop(0);
        tick(); tick(); tick(); tick();               // c0+15
        drop(1);
        tick();                                       // c0+16 idle

        // Single read: strobe in cycle 1 only, ack + data in cycle 2
        c0 = cyc_cnt;
        go(0, 1'b0, 3'd2, 32'h0);
        expect_resp(0, 1'b0, 32'h0012_3456, c0 + 2);
        @(negedge clk); chk("rd_stb_c0", 32'(bus.s_stb_o), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_stb_c1",   32'(bus.s_stb_o), 32'd1);
        chk("rd_grant_c1", 32'(bus.grant_o), 32'd1);
        chk("rd_adr_c1",   32'(bus.s_adr_o), 32'd2);
        chk("rd_we_c1",    32'(bus.s_we_o),  32'd0);
        tick();
        @(negedge clk);
        chk("rd_stb_c2",    32'(bus.s_stb_o), 32'd0);
        chk("rd_cyc_c2",    32'(bus.s_cyc_o), 32'd1);
        chk("rd_m1_dat_kept", bus.m1_dat_o,   32'hA0A0_0000);
        tick();
        drop(0);
        @(negedge clk);
        chk("rd_held_cyc",  32'(bus.s_cyc_o), 32'd1);
        chk("rd_dat_held",  bus.m0_dat_o,     32'h0012_3456);
        tick();
        @(negedge clk);
        chk("rd_rel_grant", 32'(bus.grant_o), 32'd0);
        chk("rd_rel_cyc",   32'(bus.s_cyc_o), 32'd0);
        tick();

        // Locked back-to-back writes by m0 while m1 waits
        c0 = cyc_cnt;
        go(0, 1'b1, 3'd1, 32'h1111_1111);
        expect_resp(0, 1'b0, 32'hA0A0_0001, c0 + 2);
        expect_resp(0, 1'b0, 32'h0012_3456, c0 + 5);
        expect_resp(0, 1'b0, 32'h1111_1111, c0 + 8);
        expect_resp(1, 1'b0, 32'h2222_2222, c0 + 12);
        tick();                                       // c0+1
        go(1, 1'b0, 3'd2, 32'h0);
        tick(); tick();                               // c0+3
        go(0, 1'b1, 3'd2, 32'h2222_2222);
        tick();                                       // c0+4
        @(negedge clk); chk("lock_grant_c4", 32'(bus.grant_o), 32'd1);
        tick(); tick();                               // c0+6
        go(0, 1'b1, 3'd1, 32'h3333_3333);
        tick();                                       // c0+7
        @(negedge clk); chk("lock_grant_c7", 32'(bus.grant_o), 32'd1);
        tick(); tick();                               // c0+9
        drop(0);
        tick(); tick();                               // c0+11
        @(negedge clk); chk("lock_grant_m1", 32'(bus.grant_o), 32'd2);
        tick(); tick();                               // c0+13
        drop(1);
        tick();                                       // c0+14 idle

        // Idle owner forced off after HOLD_MAX=4 cycles
        c0 = cyc_cnt;
        go(0, 1'b0, 3'd1, 32'h0);
        expect_resp(0, 1'b0, 32'h3333_3333, c0 + 2);
        expect_resp(1, 1'b0, 32'hA0A0_0005, c0 + 9);
        tick(); tick(); tick();                       // c0+3
        bus.m0_stb_i = 1'b0;
        go(1, 1'b0, 3'd5, 32'h0);
        tick(); tick(); tick();                       // c0+6
        @(negedge clk);
        chk("hold_grant_c6", 32'(bus.grant_o), 32'd1);
        chk("hold_cyc_c6",   32'(bus.s_cyc_o), 32'd1);
        tick();                                       // c0+7
        @(negedge clk);
        chk("hold_rel_grant", 32'(bus.grant_o), 32'd0);
        chk("hold_rel_cyc",   32'(bus.s_cyc_o), 32'd0);
        tick();                                       // c0+8
        @(negedge clk);
        chk("hold_m1_stb",   32'(bus.s_stb_o), 32'd1);
        chk("hold_m1_grant", 32'(bus.grant_o), 32'd2);
        tick(); tick();                               // c0+10
        drop(0);
        drop(1);
        tick();                                       // c0+11 idle

        // m1 write to address 6
        c0 = cyc_cnt;
        go(1, 1'b1, 3'd6, 32'h6666_6666);
`ifdef RTC_ARB_WPROT_EN
        expect_resp(1, 1'b1, 32'h0, c0 + 1);
        tick();
        @(negedge clk); chk("wp_stb_c1", 32'(bus.s_stb_o), 32'd0);
        tick();
        drop(1);
        @(negedge clk); chk("wp_stb_c2", 32'(bus.s_stb_o), 32'd0);
        tick();
        xfer_rd(1, 3'd6, 32'hA0A0_0006);
`else
        expect_resp(1, 1'b0, 32'hA0A0_0006, c0 + 2);
        tick();
        @(negedge clk); chk("wr6_stb_c1", 32'(bus.s_stb_o), 32'd1);
        tick(); tick();
        drop(1);
        tick();
        xfer_rd(1, 3'd6, 32'h6666_6666);
`endif

        // Asynchronous reset during CAPT: no ack, bus released at once
        go(1, 1'b0, 3'd0, 32'h0);
        tick(); tick();                               // CAPT cycle
        #1 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(bus.grant_o),  32'd0);
        chk("arst_s_cyc", 32'(bus.s_cyc_o),  32'd0);
        chk("arst_ack",   32'(bus.m1_ack_o), 32'd0);
        drop(1);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_m1_dat", bus.m1_dat_o, 32'd0);
        tick();
        xfer_rd(1, 3'd2, 32'h0012_3456);

        tick(); tick();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
